// File: rtl/fetch_pkg.sv
// Shared types for the fetch/decode boundary.
package fetch_pkg;

  // One buffered instruction: its PC and the 32-bit encoding.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fifo_entry_t;

  // Encoding presented on a slot that holds no real instruction.
  localparam logic [31:0] NOP_INST = 32'd0;

endpackage

// File: rtl/inst_fifo_mem.sv
// Instruction buffer storage: two write ports, two asynchronous read ports.
// The two write addresses are always distinct, so no write-write conflict.
module inst_fifo_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  fifo_entry_t       wdata1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  fifo_entry_t       wdata2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output fifo_entry_t       rdata1,
  output fifo_entry_t       rdata2
);

  fifo_entry_t mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (we1) mem[waddr1] <= wdata1;
    if (we2) mem[waddr2] <= wdata2;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_fifo_dual.sv
// Dual-issue instruction FIFO between fetch and decode.
// Handshake: fetch presents write_en1 (and write_en2 behind it) and the
// pair is taken only when full was low at the start of the cycle; decode
// sees read_valid1/2 and pops with read_en1 (read_en2 only alongside
// read_en1). Pops beyond the number of valid entries are ignored, and
// flush/rst discard every request of that cycle.
module inst_fifo_dual
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_addr1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_addr2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_inst1,
  output logic [31:0] read_addr1,
  output logic        read_valid1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_addr2,
  output logic        read_valid2,
  output logic        empty,
  output logic        almost_empty,
  output logic        full
);

  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH - 1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [1:0]        push_n;
  logic [1:0]        pop_n;
  logic              hold;
  fifo_entry_t       wdata1;
  fifo_entry_t       wdata2;
  fifo_entry_t       rdata1;
  fifo_entry_t       rdata2;

  assign full  = (count >= CNT_FULL);
  assign hold  = rst | flush;

  // Number of entries accepted and retired this cycle.
  always_comb begin
    push_n = 2'd0;
    pop_n  = 2'd0;
    if (!full && write_en1) push_n = write_en2 ? 2'd2 : 2'd1;
    if (read_en1) begin
      if (read_en2 && (count >= CNT_TWO)) pop_n = 2'd2;
      else if (count >= CNT_ONE)          pop_n = 2'd1;
    end
  end

  assign wdata1 = '{pc: write_addr1, inst: write_inst1};
  assign wdata2 = '{pc: write_addr2, inst: write_inst2};

  inst_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .we1    (!hold && (push_n != 2'd0)),
    .waddr1 (wr_ptr),
    .wdata1 (wdata1),
    .we2    (!hold && (push_n == 2'd2)),
    .waddr2 (wr_ptr + ADDR_W'(1)),
    .wdata2 (wdata2),
    .raddr1 (rd_ptr),
    .raddr2 (rd_ptr + ADDR_W'(1)),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Pointer and occupancy update; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (hold) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(push_n);
      rd_ptr <= rd_ptr + ADDR_W'(pop_n);
      count  <= count + (ADDR_W+1)'(push_n) - (ADDR_W+1)'(pop_n);
    end
  end

  assign read_valid1  = (count >= CNT_ONE);
  assign read_valid2  = (count >= CNT_TWO);
  assign read_inst1   = read_valid1 ? rdata1.inst : NOP_INST;
  assign read_addr1   = read_valid1 ? rdata1.pc   : 32'd0;
  assign read_inst2   = read_valid2 ? rdata2.inst : NOP_INST;
  assign read_addr2   = read_valid2 ? rdata2.pc   : 32'd0;
  assign empty        = (count == '0);
  assign almost_empty = (count <= CNT_ONE);

endmodule

// File: tb/tb_inst_fifo_dual.sv
// Self-checking bench for inst_fifo_dual: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_inst_fifo_dual;
  import fetch_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        write_en1, write_en2, read_en1, read_en2;
  logic [31:0] write_inst1, write_addr1, write_inst2, write_addr2;
  logic [31:0] read_inst1, read_addr1, read_inst2, read_addr2;
  logic        read_valid1, read_valid2, empty, almost_empty, full;

  int checks   = 0;
  int failures = 0;
  fifo_entry_t q[$];

  inst_fifo_dual #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_inst1(write_inst1), .write_addr1(write_addr1),
    .write_inst2(write_inst2), .write_addr2(write_addr2),
    .read_en1(read_en1), .read_en2(read_en2),
    .read_inst1(read_inst1), .read_addr1(read_addr1), .read_valid1(read_valid1),
    .read_inst2(read_inst2), .read_addr2(read_addr2), .read_valid2(read_valid2),
    .empty(empty), .almost_empty(almost_empty), .full(full)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic fifo_entry_t mk(input logic [31:0] pc);
    fifo_entry_t e;
    e.pc   = pc;
    e.inst = pc ^ 32'h2400_5A5A;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the FIFO is an ordered list; slots are its first two items.
  task automatic check_model(input string tag);
    int n;
    fifo_entry_t e1, e2;
    n  = q.size();
    e1 = (n >= 1) ? q[0] : '0;
    e2 = (n >= 2) ? q[1] : '0;
    chk({tag, ".valid1"}, 64'(read_valid1), 64'(n >= 1));
    chk({tag, ".valid2"}, 64'(read_valid2), 64'(n >= 2));
    chk({tag, ".slot1"}, {read_addr1, read_inst1}, {e1.pc, e1.inst});
    chk({tag, ".slot2"}, {read_addr2, read_inst2}, {e2.pc, e2.inst});
    chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
    chk({tag, ".almost_empty"}, 64'(almost_empty), 64'(n <= 1));
    chk({tag, ".full"}, 64'(full), 64'(n >= DEPTH - 1));
  endtask

  // Model update from the inputs held across the active edge.
  task automatic model_update();
    int n, npop;
    bit was_full;
    if (rst || flush) begin
      q.delete();
      return;
    end
    n        = q.size();
    was_full = (n >= DEPTH - 1);
    npop     = 0;
    if (read_en1) npop = read_en2 ? ((n < 2) ? n : 2) : ((n < 1) ? n : 1);
    for (int i = 0; i < npop; i++) void'(q.pop_front());
    if (!was_full && write_en1) begin
      q.push_back('{pc: write_addr1, inst: write_inst1});
      if (write_en2) q.push_back('{pc: write_addr2, inst: write_inst2});
    end
  endtask

  task automatic drive(input logic w1, input logic w2, input fifo_entry_t e1,
                       input fifo_entry_t e2, input logic r1, input logic r2,
                       input logic fl, input logic rs);
    @(negedge clk);
    write_en1 = w1; write_en2 = w2;
    write_addr1 = e1.pc; write_inst1 = e1.inst;
    write_addr2 = e2.pc; write_inst2 = e2.inst;
    read_en1 = r1; read_en2 = r2; flush = fl; rst = rs;
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
    #1;
    write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0; flush = 0; rst = 0;
  endtask

  task automatic step(input logic w1, input logic w2, input fifo_entry_t e1,
                      input fifo_entry_t e2, input logic r1, input logic r2,
                      input logic fl, input logic rs);
    drive(w1, w2, e1, e2, r1, r2, fl, rs);
    commit();
  endtask

  typedef struct {
    logic w1, w2, r1, r2, fl;
    int   exp_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst = 1; flush = 0; write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0;
    write_inst1 = 0; write_addr1 = 0; write_inst2 = 0; write_addr2 = 0;

    // Reset state
    step(0, 0, '0, '0, 0, 0, 0, 1);
    step(0, 0, '0, '0, 0, 0, 0, 1);
    check_model("reset");

    // Vector table: inputs and the occupancy they must leave behind
    tbl[0] = '{1, 1, 0, 0, 0, 2};
    tbl[1] = '{1, 0, 0, 0, 0, 3};
    tbl[2] = '{0, 0, 1, 0, 0, 2};
    tbl[3] = '{0, 1, 0, 0, 0, 2};
    tbl[4] = '{0, 0, 0, 1, 0, 2};
    tbl[5] = '{1, 1, 1, 1, 0, 2};
    tbl[6] = '{0, 0, 1, 1, 0, 0};
    tbl[7] = '{0, 0, 1, 0, 0, 0};
    tbl[8] = '{1, 0, 0, 0, 0, 1};
    tbl[9] = '{1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].w1, tbl[i].w2, mk(32'h1000 + 32'(i) * 8), mk(32'h1004 + 32'(i) * 8),
           tbl[i].r1, tbl[i].r2, tbl[i].fl, 0);
      chk($sformatf("tbl%0d.empty", i), 64'(empty), 64'(tbl[i].exp_cnt == 0));
      chk($sformatf("tbl%0d.almost_empty", i), 64'(almost_empty), 64'(tbl[i].exp_cnt <= 1));
      chk($sformatf("tbl%0d.valid2", i), 64'(read_valid2), 64'(tbl[i].exp_cnt >= 2));
      check_model($sformatf("tbl%0d", i));
    end

    // Dual push after reset, visible the next cycle
    step(0, 0, '0, '0, 0, 0, 0, 1);
    step(1, 1, '{pc: 32'hBFC0_0000, inst: 32'h2408_0001},
               '{pc: 32'hBFC0_0004, inst: 32'h2409_0002}, 0, 0, 0, 0);
    chk("dual.slot1", {read_addr1, read_inst1}, {32'hBFC0_0000, 32'h2408_0001});
    chk("dual.slot2", {read_addr2, read_inst2}, {32'hBFC0_0004, 32'h2409_0002});
    chk("dual.flags", {read_valid1, read_valid2, empty, almost_empty}, 4'b1100);
    check_model("dual");

    // Fill to 15 with single pushes; a dual push at full is dropped
    step(0, 0, '0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      step(1, 0, mk(32'h2000 + 32'(i) * 4), '0, 0, 0, 0, 0);
      chk($sformatf("fill%0d.full", i), 64'(full), 64'(i == 14));
    end
    step(1, 1, mk(32'hDEAD_0000), mk(32'hDEAD_0004), 0, 0, 0, 0);
    chk("drop.full", 64'(full), 64'd1);
    check_model("drop");
    // Drain in order: 7 dual pops then one single leaves rd_ptr at 15
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("drain%0d.pc1", i), 64'(read_addr1), 64'(32'h2000 + 32'(i) * 8));
      chk($sformatf("drain%0d.pc2", i), 64'(read_addr2), 64'(32'h2004 + 32'(i) * 8));
      step(0, 0, '0, '0, 1, 1, 0, 0);
    end
    chk("drain.last", 64'(read_addr1), 64'(32'h2038));
    chk("drain.last_v2", 64'(read_valid2), 64'd0);
    step(0, 0, '0, '0, 1, 0, 0, 0);
    chk("drain.empty", 64'(empty), 64'd1);

    // Wrap: entries at index 15 and 0, popped together
    step(1, 1, mk(32'h100), mk(32'h104), 0, 0, 0, 0);
    chk("wrap.pc1", 64'(read_addr1), 64'(32'h100));
    chk("wrap.pc2", 64'(read_addr2), 64'(32'h104));
    check_model("wrap_pre");
    step(0, 0, '0, '0, 1, 1, 0, 0);
    chk("wrap.empty", 64'(empty), 64'd1);
    // rd_ptr must now be 1, where the next write lands
    step(1, 0, mk(32'h200), '0, 0, 0, 0, 0);
    chk("wrap.next", {read_addr1, read_inst1}, {32'h200, 32'h200 ^ 32'h2400_5A5A});

    // count = 1, dual pop: slot 2 stays a NOP during the cycle
    drive(0, 0, '0, '0, 1, 1, 0, 0);
    #1;
    chk("one.valid2", 64'(read_valid2), 64'd0);
    chk("one.inst2", 64'(read_inst2), 64'd0);
    commit();
    chk("one.empty", 64'(empty), 64'd1);

    // count = 4, dual push + dual pop together
    step(1, 1, mk(32'h300), mk(32'h304), 0, 0, 0, 0);
    step(1, 1, mk(32'h308), mk(32'h30C), 0, 0, 0, 0);
    step(1, 1, mk(32'h310), mk(32'h314), 1, 1, 0, 0);
    chk("steady.pc1", 64'(read_addr1), 64'(32'h308));
    chk("steady.pc2", 64'(read_addr2), 64'(32'h30C));
    check_model("steady");
    step(0, 0, '0, '0, 1, 1, 0, 0);
    chk("steady.pc3", 64'(read_addr1), 64'(32'h310));
    chk("steady.pc4", 64'(read_addr2), 64'(32'h314));

    // count = 6, flush with dual push
    step(1, 1, mk(32'h400), mk(32'h404), 0, 0, 0, 0);
    step(1, 1, mk(32'h408), mk(32'h40C), 0, 0, 0, 0);
    step(1, 1, mk(32'h410), mk(32'h414), 1, 1, 1, 0);
    chk("flush.flags", {read_valid1, read_valid2, empty, almost_empty, full}, 5'b00110);
    check_model("flush");
    step(1, 1, mk(32'h500), mk(32'h504), 0, 0, 0, 0);
    step(1, 1, mk(32'h508), mk(32'h50C), 0, 0, 0, 0);
    step(1, 1, mk(32'h510), mk(32'h514), 1, 0, 0, 1);
    chk("rst.flags", {read_valid1, read_valid2, empty, almost_empty, full}, 5'b00110);
    check_model("rst");

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic w1, w2, r1, r2, fl, rs;
      w1 = ($urandom_range(0, 3) != 0);
      w2 = ($urandom_range(0, 2) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 63) == 0);
      rs = ($urandom_range(0, 255) == 0);
      step(w1, w2, mk($urandom), mk($urandom), r1, r2, fl, rs);
      check_model($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
